design_39: RTL and testbench

Single-operation registered unsigned adder with a start/valid handshake. On a start pulse it captures (a + b) mod 2^W into an output register and asserts valid for exactly one cycle, one clock later. It is a leaf datapath element: an upstream controller issues start, and downstream logic samples y while valid is high.

---
 rtl/design_39_pkg.sv | 9 +
 rtl/design_39_cla.sv | 65 ++++++
 rtl/design_39.sv | 35 +++
 tb/tb_design_39.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/design_39_pkg.sv
// rtl/design_39_pkg.sv - shared widths and lookahead grouping for the registered adder
package design_39_pkg;
  localparam int DEFAULT_W = 20;
  localparam int CLA_GROUP = 4;

  function automatic int num_groups(input int w);
    return (w + CLA_GROUP - 1) / CLA_GROUP;
  endfunction
endpackage

// File: rtl/design_39_cla.sv
// rtl/design_39_cla.sv - combinational block carry-lookahead adder, 4-bit groups
module design_39_cla
  import design_39_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NG = num_groups(W);
  localparam int PW = NG * CLA_GROUP;

  logic [PW-1:0] a_p;
  logic [PW-1:0] b_p;
  logic [PW-1:0] g;
  logic [PW-1:0] p;

  // Zero padding on the last partial group keeps its generate/propagate neutral.
  always_comb begin
    a_p = '0;
    b_p = '0;
    a_p[W-1:0] = a;
    b_p[W-1:0] = b;
  end

  assign g = a_p & b_p;
  assign p = a_p ^ b_p;

  always_comb begin
    logic [CLA_GROUP:0] cc;
    logic gg;
    logic gp;
    logic gcarry;
    int base;
    sum    = '0;
    cout   = 1'b0;
    cc     = '0;
    gg     = 1'b0;
    gp     = 1'b0;
    gcarry = 1'b0;
    base   = 0;
    for (int k = 0; k < NG; k++) begin
      base  = k * CLA_GROUP;
      gp    = p[base+3] & p[base+2] & p[base+1] & p[base];
      gg    = g[base+3]
            | (p[base+3] & g[base+2])
            | (p[base+3] & p[base+2] & g[base+1])
            | (p[base+3] & p[base+2] & p[base+1] & g[base]);
      cc[0] = gcarry;
      cc[1] = g[base] | (p[base] & gcarry);
      cc[2] = g[base+1] | (p[base+1] & g[base]) | (p[base+1] & p[base] & gcarry);
      cc[3] = g[base+2] | (p[base+2] & g[base+1]) | (p[base+2] & p[base+1] & g[base])
            | (p[base+2] & p[base+1] & p[base] & gcarry);
      // Group carry skips the ripple through the four bit positions.
      cc[4] = gg | (gp & gcarry);
      for (int j = 0; j < CLA_GROUP; j++) begin
        if (base + j < W) sum[base+j] = p[base+j] ^ cc[j];
        if (base + j + 1 == W) cout = cc[j+1];
      end
      gcarry = cc[4];
    end
  end
endmodule

// File: rtl/design_39.sv
// rtl/design_39.sv - single-operation registered adder with start/valid handshake
module design_39
  import design_39_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         valid
);
  logic [W-1:0] sum;
  logic         cla_cout_unused;

  design_39_cla #(.W(W)) u_cla (
    .a    (a),
    .b    (b),
    .sum  (sum),
    .cout (cla_cout_unused)
  );

  // y holds its last result between starts; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= start;
      if (start) y <= sum;
    end
  end
endmodule

// File: tb/tb_design_39.sv
// tb/tb_design_39.sv - scoreboard bench for design_39 at W=20, W=7 and W=1
module tb_design_39;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st20 = 1'b0;
  logic [19:0] a20 = '0, b20 = '0, y20;
  logic        v20;
  logic        st7 = 1'b0;
  logic [6:0]  a7 = '0, b7 = '0, y7;
  logic        v7;
  logic        st1 = 1'b0;
  logic [0:0]  a1 = '0, b1 = '0, y1;
  logic        v1;

  int compared = 0;
  int mismatched = 0;

  logic [19:0] q20[$];
  logic [6:0]  q7[$];
  logic [0:0]  q1[$];
  logic [19:0] last20 = '0;
  logic [6:0]  last7 = '0;
  logic [0:0]  last1 = '0;

  design_39 #(.W(20)) u20 (.clk(clk), .rst_n(rst_n), .start(st20), .a(a20), .b(b20), .y(y20), .valid(v20));
  design_39 #(.W(7))  u7  (.clk(clk), .rst_n(rst_n), .start(st7),  .a(a7),  .b(b7),  .y(y7),  .valid(v7));
  design_39 #(.W(1))  u1  (.clk(clk), .rst_n(rst_n), .start(st1),  .a(a1),  .b(b1),  .y(y1),  .valid(v1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    q20.delete();
    q7.delete();
    q1.delete();
    last20 = '0;
    last7  = '0;
    last1  = '0;
  endtask

  // Push expectations for this edge, advance one clock, then compare all three DUTs.
  task automatic tick(input string tag);
    if (rst_n && st20) q20.push_back(20'(a20 + b20));
    if (rst_n && st7)  q7.push_back(7'(a7 + b7));
    if (rst_n && st1)  q1.push_back(1'(a1 + b1));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      clear_model();
      chk({tag, "/v20"}, 20'(v20), 20'd0);
      chk({tag, "/v7"},  20'(v7),  20'd0);
      chk({tag, "/v1"},  20'(v1),  20'd0);
    end else begin
      if (q20.size() > 0) begin
        last20 = q20.pop_front();
        chk({tag, "/v20"}, 20'(v20), 20'd1);
      end else chk({tag, "/v20"}, 20'(v20), 20'd0);
      if (q7.size() > 0) begin
        last7 = q7.pop_front();
        chk({tag, "/v7"}, 20'(v7), 20'd1);
      end else chk({tag, "/v7"}, 20'(v7), 20'd0);
      if (q1.size() > 0) begin
        last1 = q1.pop_front();
        chk({tag, "/v1"}, 20'(v1), 20'd1);
      end else chk({tag, "/v1"}, 20'(v1), 20'd0);
    end
    chk({tag, "/y20"}, y20, last20);
    chk({tag, "/y7"},  20'(y7), 20'(last7));
    chk({tag, "/y1"},  20'(y1), 20'(last1));
  endtask

  initial begin
    #1;
    chk("por_y20", y20, 20'd0);
    chk("por_v20", 20'(v20), 20'd0);
    for (int i = 0; i < 3; i++) begin
      st20 = (i % 2 == 0);
      a20  = 20'($urandom);
      b20  = 20'($urandom);
      tick("rst_hold");
    end
    #2 rst_n = 1'b1;

    st20 = 1'b1; a20 = 20'h003FF; b20 = 20'h00001;
    tick("basic");
    chk("basic_y", y20, 20'h00400);
    st20 = 1'b0; a20 = 20'hABCDE; b20 = 20'h12345;
    tick("basic_hold");
    chk("basic_hold_y", y20, 20'h00400);

    st20 = 1'b1; a20 = 20'hFFFFF; b20 = 20'h00001;
    tick("wrap1");
    chk("wrap1_y", y20, 20'h00000);
    a20 = 20'hFFFFF; b20 = 20'hFFFFF;
    tick("wrap2");
    chk("wrap2_y", y20, 20'hFFFFE);
    st20 = 1'b0;
    tick("wrap_idle");

    st20 = 1'b1; a20 = 20'd1; b20 = 20'd2;
    tick("b2b0");
    chk("b2b0_y", y20, 20'h00003);
    a20 = 20'd10; b20 = 20'd20;
    tick("b2b1");
    chk("b2b1_y", y20, 20'h0001E);
    a20 = 20'h80000; b20 = 20'h80000;
    tick("b2b2");
    chk("b2b2_y", y20, 20'h00000);
    st20 = 1'b0;
    tick("b2b_idle");

    st20 = 1'b1; a20 = 20'h00123; b20 = 20'h00456;
    tick("pre_clear");
    st20 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_y20", y20, 20'd0);
    chk("async_v20", 20'(v20), 20'd0);
    clear_model();
    tick("clear_hold");
    #2 rst_n = 1'b1;

    st20 = 1'b1; a20 = 20'h0000F; b20 = 20'h00011;
    tick("release_start");
    chk("release_y", y20, 20'h00020);

    a20 = 20'd5; b20 = 20'd7;
    tick("midop");
    chk("midop_y", y20, 20'h0000C);
    st20 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midop_clr_y", y20, 20'd0);
    chk("midop_clr_v", 20'(v20), 20'd0);
    clear_model();
    tick("midop_hold");
    #2 rst_n = 1'b1;
    tick("midop_after0");
    tick("midop_after1");
    chk("midop_after_y", y20, 20'd0);

    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < 13; t++) begin
        st20 = (t < 10); a20 = 20'($urandom); b20 = 20'($urandom);
        st7  = (t < 10); a7  = 7'($urandom);  b7  = 7'($urandom);
        st1  = (t < 10); a1  = 1'($urandom);  b1  = 1'($urandom);
        tick("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
